// File: rtl/aes_run_sequencer.sv
// Run sequencer for the AES-256 core: launches incrementing-plaintext runs,
// drives a scope trigger per run, and tallies pass/fail/timeout results.
module aes_run_sequencer #(
  parameter logic [15:0]  NUM_RUNS   = 16'd1000,
  parameter logic [7:0]   TRIG_DELAY = 8'd0,
  parameter logic [7:0]   TRIG_WIDTH = 8'd8,
  parameter logic [7:0]   GAP_CYCLES = 8'd16,
  parameter logic [7:0]   TIMEOUT    = 8'd255,
  parameter logic [127:0] PT_SEED    = 128'h0
) (
  input  logic         TOP_Clk,
  input  logic         TOP_ResetAll,
  input  logic         enable,
  input  logic         core_done,
  input  logic         core_match,
  output logic         core_start,
  output logic [127:0] pt_out,
  output logic         trigger,
  output logic [15:0]  run_count,
  output logic [15:0]  fail_count,
  output logic         CompareFlag_p,
  output logic         timeout_err,
  output logic         all_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_e;

  state_e         state_q;
  logic           en_q;
  logic [7:0]     wait_q;
  logic [7:0]     wait_d;
  logic [7:0]     gap_q;
  logic           start_q;
  logic [127:0]   pt_q;
  logic [15:0]    run_q;
  logic [15:0]    fail_q;
  logic [15:0]    fail_d;
  logic           flag_q;
  logic           terr_q;
  logic           done_q;
  logic [8:0]     tcnt_q;
  logic [8:0]     tcnt_d;
  logic           trig_q;

  assign wait_d = wait_q + 8'd1;
  assign fail_d = (fail_q == 16'hFFFF) ? fail_q : fail_q + 16'd1;

  always_ff @(posedge TOP_Clk) begin
    if (TOP_ResetAll) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      wait_q  <= 8'd0;
      gap_q   <= 8'd0;
      start_q <= 1'b0;
      pt_q    <= PT_SEED;
      run_q   <= 16'd0;
      fail_q  <= 16'd0;
      flag_q  <= 1'b0;
      terr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q    <= enable;
      start_q <= 1'b0;
      flag_q  <= (run_q != 16'd0) && (fail_q == 16'd0);
      unique case (state_q)
        S_IDLE: begin
          if (en_q) begin
            state_q <= S_LAUNCH;
            start_q <= 1'b1;
            run_q   <= 16'd0;
            fail_q  <= 16'd0;
            terr_q  <= 1'b0;
            flag_q  <= 1'b0;
            pt_q    <= PT_SEED;
          end
        end
        S_LAUNCH: begin
          wait_q  <= 8'd0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wait_q <= wait_d;
          // a done on the timeout cycle still counts as a real answer
          if (core_done) begin
            run_q   <= run_q + 16'd1;
            if (!core_match) fail_q <= fail_d;
            gap_q   <= 8'd0;
            state_q <= S_GAP;
          end else if (wait_d == TIMEOUT) begin
            run_q   <= run_q + 16'd1;
            fail_q  <= fail_d;
            terr_q  <= 1'b1;
            gap_q   <= 8'd0;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_CYCLES - 8'd1) begin
            pt_q <= pt_q + 128'd1;
            if (NUM_RUNS != 16'd0 && run_q == NUM_RUNS) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (!en_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_LAUNCH;
              start_q <= 1'b1;
            end
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        S_DONE: begin
          if (!en_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // window counts down from DELAY+WIDTH; high while it sits in 1..WIDTH
  always_comb begin
    tcnt_d = 9'd0;
    if (state_q == S_LAUNCH) begin
      tcnt_d = {1'b0, TRIG_DELAY} + {1'b0, TRIG_WIDTH};
    end else if (tcnt_q != 9'd0) begin
      tcnt_d = tcnt_q - 9'd1;
    end
  end

  always_ff @(posedge TOP_Clk) begin
    if (TOP_ResetAll) begin
      tcnt_q <= 9'd0;
      trig_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      trig_q <= (tcnt_d != 9'd0) && (tcnt_d <= {1'b0, TRIG_WIDTH});
    end
  end

  assign core_start    = start_q;
  assign pt_out        = pt_q;
  assign trigger       = trig_q;
  assign run_count     = run_q;
  assign fail_count    = fail_q;
  assign CompareFlag_p = flag_q;
  assign timeout_err   = terr_q;
  assign all_done      = done_q;

endmodule

// File: tb/tb_aes_run_sequencer.sv
// Directed bench for aes_run_sequencer: table-driven campaigns on one
// instance, hand sequences for enable drop, reset, wrap and trigger merge.
module tb_aes_run_sequencer;

  localparam int GAP_A = 4;
  localparam int TMO_A = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         en_a, done_a, match_a;
  logic         en_b, done_b, match_b;
  logic         start_a, trig_a, flag_a, terr_a, alld_a;
  logic         start_b, trig_b, flag_b, terr_b, alld_b;
  logic [127:0] pt_a, pt_b;
  logic [15:0]  run_a, fail_a, run_b, fail_b;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_run_sequencer #(
    .NUM_RUNS(16'd3), .TRIG_DELAY(8'd3), .TRIG_WIDTH(8'd5),
    .GAP_CYCLES(8'd4), .TIMEOUT(8'd20), .PT_SEED(128'h0)
  ) u_a (
    .TOP_Clk(clk), .TOP_ResetAll(rst), .enable(en_a),
    .core_done(done_a), .core_match(match_a),
    .core_start(start_a), .pt_out(pt_a), .trigger(trig_a),
    .run_count(run_a), .fail_count(fail_a),
    .CompareFlag_p(flag_a), .timeout_err(terr_a), .all_done(alld_a)
  );

  aes_run_sequencer #(
    .NUM_RUNS(16'd2), .TRIG_DELAY(8'd0), .TRIG_WIDTH(8'd8),
    .GAP_CYCLES(8'd1), .TIMEOUT(8'd255), .PT_SEED({128{1'b1}})
  ) u_b (
    .TOP_Clk(clk), .TOP_ResetAll(rst), .enable(en_b),
    .core_done(done_b), .core_match(match_b),
    .core_start(start_b), .pt_out(pt_b), .trigger(trig_b),
    .run_count(run_b), .fail_count(fail_b),
    .CompareFlag_p(flag_b), .timeout_err(terr_b), .all_done(alld_b)
  );

  typedef struct {
    bit          first;
    bit          last;
    int          lat;
    bit          match;
    logic [15:0] e_run;
    logic [15:0] e_fail;
    bit          e_terr;
    bit          e_flag;
  } vec_t;

  vec_t        tbl [9];
  vec_t        v;
  int          s, t_upd, exp_next, ridx;
  bit          ok, seen;
  bit          prev_flag;
  logic [15:0] prev_run;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk128(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en_a = 1'b0; done_a = 1'b0; match_a = 1'b0;
    en_b = 1'b0; done_b = 1'b0; match_b = 1'b0;

    // first, last, latency(0 = never), match, run, fail, terr, flag
    tbl[0] = '{1'b1, 1'b0, 10, 1'b1, 16'd1, 16'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 10, 1'b1, 16'd2, 16'd0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 10, 1'b1, 16'd3, 16'd0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 20, 1'b1, 16'd1, 16'd0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 10, 1'b0, 16'd2, 16'd1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1,  5, 1'b1, 16'd3, 16'd1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0,  0, 1'b0, 16'd1, 16'd1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 10, 1'b1, 16'd2, 16'd1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 10, 1'b1, 16'd3, 16'd1, 1'b1, 1'b0};

    step(); step();
    chk1("rst_start", start_a, 1'b0);
    chk1("rst_trig", trig_a, 1'b0);
    chk16("rst_run", run_a, 16'd0);
    chk16("rst_fail", fail_a, 16'd0);
    chk1("rst_flag", flag_a, 1'b0);
    chk1("rst_terr", terr_a, 1'b0);
    chk1("rst_done", alld_a, 1'b0);
    chk128("rst_pt_a", pt_a, 128'h0);
    chk128("rst_pt_b", pt_b, {128{1'b1}});
    rst = 1'b0;
    step();

    prev_run = 16'd0;
    prev_flag = 1'b0;
    ridx = 0;
    exp_next = 0;
    for (int i = 0; i < 9; i++) begin
      v = tbl[i];
      if (v.first) begin
        en_a = 1'b1;
        step();
        chk1("en_lat_nostart", start_a, 1'b0);
        chk16("run_held_idle", run_a, prev_run);
        step();
        chk1("en_lat_start", start_a, 1'b1);
        chk16("run_clr", run_a, 16'd0);
        chk16("fail_clr", fail_a, 16'd0);
        chk1("terr_clr", terr_a, 1'b0);
        prev_run = 16'd0;
        prev_flag = 1'b0;
        ridx = 0;
      end else begin
        ok = 1'b0;
        for (int w = 0; w < 60 && !ok; w++) begin
          if (start_a) ok = 1'b1;
          else step();
        end
        chk1("start_seen", ok, 1'b1);
        chki("start_cycle", cyc, exp_next);
      end
      s = cyc;
      chk128("pt_run", pt_a, 128'(ridx));
      t_upd = (v.lat == 0) ? TMO_A + 1 : v.lat + 1;
      for (int k = 1; k <= t_upd + 1; k++) begin
        step();
        done_a = (k == v.lat);
        match_a = (k == v.lat) ? v.match : 1'b0;
        if (k <= 10) chk1("trig_win", trig_a, (k >= 4 && k <= 8));
        if (k == t_upd - 1) chk16("run_pre", run_a, prev_run);
        if (k == t_upd) begin
          chk16("run_upd", run_a, v.e_run);
          chk16("fail_upd", fail_a, v.e_fail);
          chk1("terr_upd", terr_a, v.e_terr);
          chk1("flag_lag", flag_a, prev_flag);
        end
        if (k == t_upd + 1) begin
          chk1("flag_upd", flag_a, v.e_flag);
          done_a = (v.lat == 0);
        end
      end
      step();
      done_a = 1'b0;
      match_a = 1'b0;
      chk16("run_gap_done_ign", run_a, v.e_run);
      chk16("fail_gap_done_ign", fail_a, v.e_fail);
      exp_next = s + t_upd + GAP_A;
      if (v.last) begin
        while (cyc < exp_next) step();
        chk1("all_done", alld_a, 1'b1);
        chk1("done_nostart", start_a, 1'b0);
        en_a = 1'b0;
        step(); step(); step();
        chk1("all_done_clr", alld_a, 1'b0);
        chk16("run_persist", run_a, v.e_run);
      end
      prev_run = v.e_run;
      prev_flag = v.e_flag;
      ridx++;
    end

    // enable dropped mid-WAIT: run completes, then back to IDLE
    en_a = 1'b1;
    step(); step();
    chk1("drop_start", start_a, 1'b1);
    chk1("drop_terr_clr", terr_a, 1'b0);
    seen = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      done_a = (k == 10);
      match_a = (k == 10);
      if (k == 2) en_a = 1'b0;
      if (k >= 11 && start_a) seen = 1'b1;
    end
    chk1("drop_no_relaunch", seen, 1'b0);
    chk16("drop_run", run_a, 16'd1);
    chk16("drop_fail", fail_a, 16'd0);
    chk1("drop_flag", flag_a, 1'b1);
    chk1("drop_not_done", alld_a, 1'b0);

    // reset pulse in the WAIT of the second run
    en_a = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      step();
      if (start_a) ok = 1'b1;
    end
    chk1("rr_start1", ok, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      step();
      done_a = (k == 10);
      match_a = (k == 10);
    end
    step();
    done_a = 1'b0;
    match_a = 1'b0;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      if (start_a) ok = 1'b1;
      else step();
    end
    chk1("rr_start2", ok, 1'b1);
    chk16("rr_run_before", run_a, 16'd1);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("rr_start", start_a, 1'b0);
    chk1("rr_trig", trig_a, 1'b0);
    chk16("rr_run", run_a, 16'd0);
    chk16("rr_fail", fail_a, 16'd0);
    chk1("rr_flag", flag_a, 1'b0);
    chk1("rr_terr", terr_a, 1'b0);
    chk1("rr_done", alld_a, 1'b0);
    chk128("rr_pt", pt_a, 128'h0);
    step();
    chk1("rr_nostart_after", start_a, 1'b0);
    en_a = 1'b0;

    // wrap of all-ones seed and merged back-to-back trigger windows
    en_b = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      step();
      if (start_b) ok = 1'b1;
    end
    chk1("wrap_start1", ok, 1'b1);
    chk128("wrap_pt1", pt_b, {128{1'b1}});
    chk1("merge_trig_k0", trig_b, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      done_b = (k == 1 || k == 4);
      match_b = 1'b1;
      chk1("merge_trig", trig_b, (k <= 11));
      if (k == 2) chk1("wrap_gap_nostart", start_b, 1'b0);
      if (k == 3) begin
        chk1("wrap_start2", start_b, 1'b1);
        chk128("wrap_pt2", pt_b, 128'h0);
      end
      if (k == 5) chk1("wrap_not_done", alld_b, 1'b0);
      if (k == 6) chk1("wrap_done", alld_b, 1'b1);
    end
    done_b = 1'b0;
    chk16("wrap_run", run_b, 16'd2);
    chk16("wrap_fail", fail_b, 16'd0);
    chk1("wrap_flag", flag_b, 1'b1);
    en_b = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
